// File: rtl/pconv_pkg.sv
// Shared widths, pipeline tag record and the output clamp for the pointwise convolution unit.
package pconv_pkg;

    localparam int unsigned ACC_W   = 32;
    localparam int unsigned SHIFT_W = 5;
    // Headroom for acc + bias + rounding term without overflow.
    localparam int unsigned T_W     = ACC_W + 2;

    typedef struct packed {
        logic               vld;
        logic               first;
        logic               last;
        logic [ACC_W-1:0]   bias;
        logic [SHIFT_W-1:0] shift;
        logic               relu;
    } pconv_tag_t;

    // Clamps to [0,max_val] (relu) or [-max_val-1,max_val]; callers keep the low N bits.
    function automatic logic signed [ACC_W-1:0] clamp_sat(input logic signed [T_W-1:0] value,
                                                          input logic                  relu,
                                                          input int                    max_val);
        logic signed [T_W-1:0] hi;
        logic signed [T_W-1:0] lo;
        logic signed [T_W-1:0] res;
        hi = T_W'(max_val);
        lo = relu ? '0 : -hi - T_W'(1);
        if (value > hi) begin
            res = hi;
        end else if (value < lo) begin
            res = lo;
        end else begin
            res = value;
        end
        return res[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/pconv_sum_tree.sv
// Registered signed adder tree: sign-extends LANES inputs to ACC_W and sums them in two
// register levels (half sums, then total) so the latency does not depend on LANES.
module pconv_sum_tree
    import pconv_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned IN_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [LANES*IN_W-1:0]   din,
    output logic signed [ACC_W-1:0] sum
);

    localparam int unsigned HALF = LANES / 2;

    logic signed [ACC_W-1:0] lo_d, hi_d;
    logic signed [ACC_W-1:0] lo_q, hi_q;

    always_comb begin
        lo_d = '0;
        hi_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (i < HALF) begin
                lo_d = lo_d + ACC_W'($signed(din[i*IN_W +: IN_W]));
            end else begin
                hi_d = hi_d + ACC_W'($signed(din[i*IN_W +: IN_W]));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q <= '0;
            hi_q <= '0;
            sum  <= '0;
        end else if (en) begin
            lo_q <= lo_d;
            hi_q <= hi_d;
            sum  <= lo_q + hi_q;
        end
    end

endmodule

// File: rtl/pconv_acc_unit.sv
// Pipelined 1x1 convolution for one output channel: LANES channels per beat over BEATS beats,
// then bias, shift and clamp. Define PCONV_ROUND_EN for round-half-up before the shift.
module pconv_acc_unit
    import pconv_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned LANES = 4,
    parameter int unsigned BEATS = 2,
    parameter int          MAX   = 127
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [LANES*N-1:0]   in_din,
    input  logic [LANES*N-1:0]   weight_din,
    input  logic [ACC_W-1:0]     bias_din,
    input  logic [SHIFT_W-1:0]   shift_din,
    input  logic                 relu_en,
    output logic [N-1:0]         out_dout,
    output logic                 out_vld,
    input  logic                 out_rdy
);

    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PROD_W = 2 * N;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    logic stall, adv, accept, first, last;
    logic [CNT_W-1:0] cnt_q;

    // Every register advances together, so a stall freezes the whole pipe.
    assign stall  = out_vld && !out_rdy;
    assign adv    = !stall;
    assign in_rdy = adv;
    assign accept = in_vld && in_rdy;
    assign first  = (cnt_q == '0);
    assign last   = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // S1: lane products plus tags
    logic [LANES*PROD_W-1:0] s1_prod_d, s1_prod_q;
    pconv_tag_t              s1_tag_d, s1_tag_q;

    always_comb begin
        s1_prod_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            s1_prod_d[i*PROD_W +: PROD_W] = PROD_W'($signed(in_din[i*N +: N])) *
                                            PROD_W'($signed(weight_din[i*N +: N]));
        end
        s1_tag_d       = '0;
        s1_tag_d.vld   = accept;
        s1_tag_d.first = first;
        s1_tag_d.last  = last;
        s1_tag_d.bias  = bias_din;
        s1_tag_d.shift = shift_din;
        s1_tag_d.relu  = relu_en;
    end

    // S2: two-level tree; tags follow through a matching two-deep delay
    logic signed [ACC_W-1:0] s2_sum;
    pconv_tag_t              s2a_tag_q, s2_tag_q;

    pconv_sum_tree #(
        .LANES (LANES),
        .IN_W  (PROD_W)
    ) u_sum_tree (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .din (s1_prod_q),
        .sum (s2_sum)
    );

    // S3: accumulator
    logic signed [ACC_W-1:0] acc_q;
    pconv_tag_t              s3_tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_prod_q <= '0;
            s1_tag_q  <= '0;
            s2a_tag_q <= '0;
            s2_tag_q  <= '0;
            s3_tag_q  <= '0;
            acc_q     <= '0;
        end else if (adv) begin
            s1_prod_q <= s1_prod_d;
            s1_tag_q  <= s1_tag_d;
            s2a_tag_q <= s1_tag_q;
            s2_tag_q  <= s2a_tag_q;
            s3_tag_q  <= s2_tag_q;
            if (s2_tag_q.vld) begin
                acc_q <= s2_tag_q.first ? s2_sum : acc_q + s2_sum;
            end
        end
    end

    // S4: bias, shift, clamp
    logic signed [T_W-1:0]   t_sum, t_rnd, t_shift;
    logic signed [ACC_W-1:0] t_clamp;
    logic                    load;
    logic                    unused_bits;

    always_comb begin
`ifdef PCONV_ROUND_EN
        t_rnd = (s3_tag_q.shift != '0) ? (T_W'(1) <<< (s3_tag_q.shift - SHIFT_W'(1))) : '0;
`else
        t_rnd = '0;
`endif
        t_sum   = T_W'(acc_q) + T_W'($signed(s3_tag_q.bias)) + t_rnd;
        t_shift = t_sum >>> s3_tag_q.shift;
        t_clamp = clamp_sat(t_shift, s3_tag_q.relu, MAX);
    end

    assign load        = s3_tag_q.vld && s3_tag_q.last;
    assign unused_bits = ^{s3_tag_q.first, t_clamp[ACC_W-1:N]};

    // When adv is high any held result is being consumed, so out_vld simply tracks load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_dout <= '0;
        end else if (adv) begin
            out_vld <= load;
            if (load) begin
                out_dout <= t_clamp[N-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pconv_acc_unit.sv
// Self-checking bench for pconv_acc_unit (N=16, LANES=4, BEATS=2, MAX=127).
module tb_pconv_acc_unit;

    localparam int N     = 16;
    localparam int LANES = 4;
    localparam int BEATS = 2;
    localparam int MAX   = 127;
    localparam int CH    = LANES * BEATS;

    typedef logic [CH-1:0][N-1:0] chan_t;
    typedef struct packed {
        chan_t       act;
        chan_t       wgt;
        logic [31:0] bias;
        logic [4:0]  shift;
        logic        relu;
        logic [15:0] exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_vld = 1'b0;
    logic              in_rdy;
    logic [LANES*N-1:0] in_din = '0;
    logic [LANES*N-1:0] weight_din = '0;
    logic [31:0]       bias_din = '0;
    logic [4:0]        shift_din = '0;
    logic              relu_en = 1'b0;
    logic [N-1:0]      out_dout;
    logic              out_vld;
    logic              out_rdy = 1'b1;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic        hold_pend = 1'b0;
    logic [15:0] hold_val;
    logic [15:0] mon_e;
    logic        rand_done = 1'b0;
    vec_t        vecs[8];
    vec_t        bp[3];
    int          lat;
    logic [15:0] held;

    always #5 clk = ~clk;

    pconv_acc_unit #(
        .N     (N),
        .LANES (LANES),
        .BEATS (BEATS),
        .MAX   (MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_din     (in_din),
        .weight_din (weight_din),
        .bias_din   (bias_din),
        .shift_din  (shift_din),
        .relu_en    (relu_en),
        .out_dout   (out_dout),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy)
    );

    // Reference: dot product, 32-bit wrap, bias, optional rounding, floor shift, clamp.
    function automatic logic [15:0] ref_model(chan_t act, chan_t wgt, logic [31:0] bias,
                                              logic [4:0] shift, logic relu);
        longint s;
        longint t;
        int     acc;
        s = 0;
        for (int i = 0; i < CH; i++) begin
            s += longint'($signed(act[i])) * longint'($signed(wgt[i]));
        end
        acc = int'(s);
        t = longint'(acc) + longint'($signed(bias));
`ifdef PCONV_ROUND_EN
        if (shift != 0) t += longint'(1) << (shift - 1);
`endif
        t = t >>> shift;
        if (t > MAX) t = MAX;
        else if (relu && t < 0) t = 0;
        else if (t < -MAX - 1) t = -MAX - 1;
        return 16'(t);
    endfunction

    function automatic vec_t mk(int a, int w, int b, int sh, int r, int e);
        vec_t v;
        for (int i = 0; i < CH; i++) begin
            v.act[i] = 16'(a);
            v.wgt[i] = 16'(w);
        end
        v.bias  = 32'(b);
        v.shift = 5'(sh);
        v.relu  = 1'(r);
        v.exp   = 16'(e);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, expv);
        end
    endtask

    task automatic send_beat(input logic [63:0] a, input logic [63:0] w, input logic [31:0] b,
                             input logic [4:0] sh, input logic r);
        int waited;
        waited     = 0;
        in_vld     = 1'b1;
        in_din     = a;
        weight_din = w;
        bias_din   = b;
        shift_din  = sh;
        relu_en    = r;
        @(negedge clk);
        while (!in_rdy) begin
            waited++;
            if (waited > 300) begin
                checks++;
                errors++;
                $display("FAIL in_rdy_timeout: in_rdy=0 for %0d cycles, expected 1", waited);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    // First beat carries junk sideband when asked; only the last beat's copy may matter.
    task automatic send_pixel(input vec_t v, input logic junk);
        send_beat(v.act[3:0], v.wgt[3:0], junk ? 32'($urandom) : v.bias,
                  junk ? 5'($urandom) : v.shift, junk ? 1'($urandom) : v.relu);
        send_beat(v.act[7:4], v.wgt[7:4], v.bias, v.shift, v.relu);
    endtask

    task automatic wait_out(output int l);
        l = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_vld) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in_vld = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard on handshakes, plus output stability while stalled.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (hold_pend) begin
                checks++;
                if (!(out_vld === 1'b1 && out_dout === hold_val)) begin
                    errors++;
                    $display("FAIL stall_hold: vld=%0b dout=%0h, expected vld=1 dout=%0h",
                             out_vld, out_dout, hold_val);
                end
            end
            hold_pend = out_vld && !out_rdy;
            hold_val  = out_dout;
            if (out_vld && out_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_result: got %0h, expected no result", out_dout);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_dout !== mon_e) begin
                        errors++;
                        $display("FAIL result: got %0h, expected %0h", out_dout, mon_e);
                    end
                end
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(1, 2, 0, 0, 1, 16);
        vecs[1] = mk(100, 100, 0, 4, 1, 127);
        vecs[2] = mk(100, -100, 0, 4, 0, -128);
        vecs[3] = mk(5, -3, 0, 0, 1, 0);
        vecs[4] = mk(5, -3, 0, 0, 0, -120);
`ifdef PCONV_ROUND_EN
        vecs[5] = mk(0, 0, 0, 2, 0, 6);
`else
        vecs[5] = mk(0, 0, 0, 2, 0, 5);
`endif
        vecs[5].act[0] = 16'd23;
        vecs[5].wgt[0] = 16'd1;
        vecs[6] = mk(0, 0, 0, 2, 0, -6);
        vecs[6].act[0] = 16'hFFE9;
        vecs[6].wgt[0] = 16'd1;
        vecs[7] = mk(3, 1, -30, 1, 0, -3);

        bp[0] = mk(2, 3, 4, 1, 0, 26);
        bp[1] = mk(-4, 5, 0, 0, 0, -128);
        bp[2] = mk(7, 1, -6, 0, 1, 50);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_dout", out_dout, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_rdy", in_rdy, 1);

        // Directed vectors: value and latency
        for (int i = 0; i < 8; i++) begin
            send_pixel(vecs[i], 1'b0);
            in_vld = 1'b0;
            wait_out(lat);
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_dout", i), out_dout, vecs[i].exp);
            idle(2);
        end

        // Backpressure: three pixels while the first result is held
        out_rdy = 1'b0;
        mon_en  = 1'b1;
        for (int p = 0; p < 3; p++) exp_q.push_back(bp[p].exp);
        fork
            begin
                for (int p = 0; p < 3; p++) send_pixel(bp[p], 1'b1);
                in_vld = 1'b0;
            end
            begin
                wait_out(lat);
                chk("bp_first_vld", out_vld, 1);
                chk("bp_first_dout", out_dout, bp[0].exp);
                held = out_dout;
                repeat (6) begin
                    @(posedge clk);
                    #1;
                    chk("bp_in_rdy", in_rdy, 0);
                    chk("bp_dout_hold", out_dout, held);
                end
                out_rdy = 1'b1;
            end
        join
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        idle(4);
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_no_extra", out_vld, 0);
        mon_en = 1'b0;

        // Reset in the middle of a pixel
        out_rdy = 1'b0;
        send_pixel(mk(2, 2, 0, 0, 0, 32), 1'b0);
        send_beat({4{16'd50}}, {4{16'd50}}, 32'd0, 5'd0, 1'b0);
        in_vld = 1'b0;
        wait_out(lat);
        chk("rstmid_pre_vld", out_vld, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_vld_async", out_vld, 0);
        chk("rstmid_dout_async", out_dout, 0);
        @(negedge clk);
        rst     = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        send_pixel(mk(1, 3, 0, 0, 0, 24), 1'b0);
        in_vld = 1'b0;
        wait_out(lat);
        chk("rstmid_fresh_latency", lat, 4);
        chk("rstmid_fresh_dout", out_dout, 24);
        idle(3);

        // Randomised traffic against the reference model
        mon_en = 1'b1;
        fork
            begin
                for (int p = 0; p < 150; p++) begin
                    vec_t v;
                    int   mode;
                    mode = $urandom_range(0, 2);
                    for (int i = 0; i < CH; i++) begin
                        if (mode == 0) begin
                            v.act[i] = 16'($urandom_range(0, 15)) - 16'd8;
                            v.wgt[i] = 16'($urandom_range(0, 15)) - 16'd8;
                        end else begin
                            v.act[i] = 16'($urandom);
                            v.wgt[i] = 16'($urandom);
                        end
                    end
                    v.bias  = (mode == 0) ? 32'($urandom_range(0, 63)) - 32'd32 : 32'($urandom);
                    v.shift = (mode == 0) ? 5'($urandom_range(0, 4)) : 5'($urandom);
                    v.relu  = 1'($urandom);
                    v.exp   = '0;
                    exp_q.push_back(ref_model(v.act, v.wgt, v.bias, v.shift, v.relu));
                    send_pixel(v, 1'b1);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                in_vld    = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_rdy = ($urandom_range(0, 3) != 0);
                end
                out_rdy = 1'b1;
            end
        join
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        idle(4);
        chk("rand_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
